// File: rtl/fft_stream_pkg.sv
// rtl/fft_stream_pkg.sv - shared types and constants for the FFT output stream sink
package fft_stream_pkg;

    localparam int CPLX_W   = 64;
    localparam int REAL_LSB = 0;
    localparam int IMAG_LSB = 32;

    typedef enum logic {
        S_CAPTURE = 1'b0,
        S_FULL    = 1'b1
    } state_t;

    function automatic int calc_addr_w(input int n_points);
        return (n_points < 2) ? 1 : $clog2(n_points);
    endfunction

endpackage

// File: rtl/fft_frame_ram.sv
// rtl/fft_frame_ram.sv - simple dual-port frame buffer with registered read port
module fft_frame_ram #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Storage has no reset so it can map onto block or distributed RAM.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fft_frame_sink.sv
// rtl/fft_frame_sink.sv - AXI4-Stream sink capturing one FFT frame with framing checks
module fft_frame_sink
    import fft_stream_pkg::*;
#(
    parameter  int N_POINTS = 8,
    parameter  int DATA_W   = CPLX_W,
    parameter  int USER_W   = 16,
    localparam int ADDR_W   = calc_addr_w(N_POINTS)
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [USER_W-1:0] s_axis_tuser,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic              frame_valid,
    output logic [15:0]       frame_count,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              frame_release,
    output logic              err_tlast_missing,
    output logic              err_tlast_unexpected,
    output logic              err_index
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(N_POINTS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] w_wr_ptr_nxt;
    logic              r_tready;
    logic [15:0]       r_frame_count;
    logic              r_err_tlast_missing;
    logic              r_err_tlast_unexpected;
    logic              r_err_index;
    logic              w_beat;
    logic              w_close;
    logic              w_early;
    logic              w_idx_bad;
    logic              w_unused_tuser;

    assign w_beat         = s_axis_tvalid & r_tready;
    assign w_idx_bad      = s_axis_tuser[ADDR_W-1:0] != r_wr_ptr;
    assign w_unused_tuser = ^s_axis_tuser;

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_close      = 1'b0;
        w_early      = 1'b0;
        case (r_state)
            S_CAPTURE: begin
                if (w_beat) begin
                    if (r_wr_ptr == LAST_PTR) begin
                        w_close      = 1'b1;
                        w_state_nxt  = S_FULL;
                        w_wr_ptr_nxt = '0;
                    end else if (s_axis_tlast) begin
                        w_early      = 1'b1;
                        w_wr_ptr_nxt = '0;
                    end else begin
                        w_wr_ptr_nxt = r_wr_ptr + ADDR_W'(1);
                    end
                end
            end
            S_FULL: begin
                if (frame_release) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            default: w_state_nxt = S_CAPTURE;
        endcase
    end

    // tready is registered from the next state so it never follows tvalid combinationally.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state                <= S_CAPTURE;
            r_wr_ptr               <= '0;
            r_tready               <= 1'b0;
            r_frame_count          <= 16'd0;
            r_err_tlast_missing    <= 1'b0;
            r_err_tlast_unexpected <= 1'b0;
            r_err_index            <= 1'b0;
        end else begin
            r_state                <= w_state_nxt;
            r_wr_ptr               <= w_wr_ptr_nxt;
            r_tready               <= (w_state_nxt == S_CAPTURE);
            if (w_close) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            r_err_tlast_missing    <= w_close & ~s_axis_tlast;
            r_err_tlast_unexpected <= w_early;
            r_err_index            <= w_beat & w_idx_bad;
        end
    end

    fft_frame_ram #(
        .DEPTH  (N_POINTS),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .i_clk   (aclk),
        .i_rst   (areset),
        .i_we    (w_beat),
        .i_waddr (r_wr_ptr),
        .i_wdata (s_axis_tdata),
        .i_re    (rd_en),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

    assign s_axis_tready        = r_tready;
    assign frame_valid          = (r_state == S_FULL);
    assign frame_count          = r_frame_count;
    assign err_tlast_missing    = r_err_tlast_missing;
    assign err_tlast_unexpected = r_err_tlast_unexpected;
    assign err_index            = r_err_index;

endmodule
